// File: rtl/bp_fe_queue_buffer.sv
// -----------------------------------------------------------------------------
// bp_fe_queue_buffer
//
// Circular FIFO between the front end's fe_queue output and the back end's
// instruction-fetch consumer. It soaks up back-pressure so the FE can keep
// fetching while the BE stalls, and it can drop every stored entry in one
// cycle when the BE redirects.
//
//   FE side : valid/ready   (fe_queue_v_i / fe_queue_ready_o)
//   BE side : valid/yumi    (fe_queue_v_o / fe_queue_yumi_i)
//
// Pointers carry one extra wrap bit above the slot index. Equal pointers mean
// empty. Equal slot bits with differing wrap bits mean full. This lets all
// els_p slots be used without a separate occupancy counter.
//
// Optional feature (off by default):
//   BP_FE_QUEUE_BYPASS_EN - when the buffer is empty, an incoming entry is
//   shown on fe_queue_o in the same cycle. If the BE takes it in that cycle,
//   it is never written. empty_o and count_o still count stored entries only.
// -----------------------------------------------------------------------------
module bp_fe_queue_buffer #(
    parameter int  els_p          = 8,
    parameter int  width_p        = 128,
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int count_width_lp = ((els_p + 1) > 1) ? $clog2(els_p + 1) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    // FE (producer) side
    input  logic [width_p-1:0]        fe_queue_i,
    input  logic                      fe_queue_v_i,
    output logic                      fe_queue_ready_o,

    // BE (consumer) side
    output logic [width_p-1:0]        fe_queue_o,
    output logic                      fe_queue_v_o,
    input  logic                      fe_queue_yumi_i,

    // Control and status
    input  logic                      clr_i,
    output logic                      empty_o,
    output logic [count_width_lp-1:0] count_o
);

    // Pointer = {wrap bit, slot index}
    logic [ptr_width_lp:0]  wptr_q, wptr_d;
    logic [ptr_width_lp:0]  rptr_q, rptr_d;
    logic [ptr_width_lp:0]  occupancy;

    logic [width_p-1:0]     mem_q [els_p];

    logic                   full;
    logic                   empty;
    logic                   enq;
    logic                   deq;
    logic                   bypass_v;
    logic                   bypass_consume;

    // Full/empty and occupancy, derived only from the registered pointers
    always_comb begin
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0])
                  & (wptr_q[ptr_width_lp]     != rptr_q[ptr_width_lp]);
        occupancy = wptr_q - rptr_q;
    end

    // Same-cycle bypass decode. It exists only in the bypass build.
    always_comb begin
`ifdef BP_FE_QUEUE_BYPASS_EN
        bypass_v       = empty & fe_queue_v_i & ~clr_i;
        bypass_consume = bypass_v & fe_queue_yumi_i;
`else
        bypass_v       = 1'b0;
        bypass_consume = 1'b0;
`endif
    end

    // Handshake decode. clr_i wins over both sides. A bypass-consumed entry
    // moves neither pointer.
    always_comb begin
        // Ready comes from registered state, plus a hold-off while in reset.
        // A full buffer refuses an entry even if the BE dequeues in that cycle.
        fe_queue_ready_o = ~full & ~reset_i;
        enq              = fe_queue_v_i & fe_queue_ready_o & ~clr_i & ~bypass_consume;
        deq              = fe_queue_yumi_i & ~clr_i & ~bypass_consume;
    end

    // Next-state pointers. A flush empties the buffer by moving read to write.
    always_comb begin
        wptr_d = wptr_q + {{ptr_width_lp{1'b0}}, enq};
        if (clr_i) begin
            rptr_d = wptr_q;
        end else begin
            rptr_d = rptr_q + {{ptr_width_lp{1'b0}}, deq};
        end
    end

    // Pointer registers; reset discards all entries immediately
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples the values from before this edge.
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage, written at the write pointer's slot
    // NOTE: the array is not reset on purpose. The pointers alone decide which
    // slots are valid, and leaving out the reset lets it map to plain RAM/flops
    // with no reset tree.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q[ptr_width_lp-1:0]] <= fe_queue_i;
        end
    end

    // BE-facing outputs and status
    always_comb begin
        fe_queue_o   = mem_q[rptr_q[ptr_width_lp-1:0]];
        fe_queue_v_o = ~empty;
        if (bypass_v) begin
            fe_queue_o   = fe_queue_i;
            fe_queue_v_o = 1'b1;
        end
        empty_o = empty;
        count_o = count_width_lp'(occupancy);
    end

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// -----------------------------------------------------------------------------
// tb_bp_fe_queue_buffer
//
// Self-checking bench for bp_fe_queue_buffer (els_p = 8, width_p = 32).
// The reference model is a plain SystemVerilog queue of stored entries.
// Every cycle, at the falling edge, the DUT outputs are compared with what the
// model says they must be. Directed sequences add literal expectations that
// pin the model. A long run of random stimulus follows.
// Build with +define+BP_FE_QUEUE_BYPASS_EN to check the bypass variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bp_fe_queue_buffer;

    localparam int ELS = 8;
    localparam int W   = 32;
    localparam int CW  = $clog2(ELS + 1);
`ifdef BP_FE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [W-1:0]  fe_queue_i;
    logic          fe_queue_v_i;
    logic          fe_queue_ready_o;
    logic [W-1:0]  fe_queue_o;
    logic          fe_queue_v_o;
    logic          fe_queue_yumi_i;
    logic          clr_i;
    logic          empty_o;
    logic [CW-1:0] count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model_q [$];

    bp_fe_queue_buffer #(.els_p(ELS), .width_p(W)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .clr_i            (clr_i),
        .empty_o          (empty_o),
        .count_o          (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs follow from the stored entries and the current inputs.
    task automatic compare_outputs();
        logic          exp_v;
        logic [W-1:0]  exp_d;
        exp_v = (model_q.size() != 0);
        exp_d = (model_q.size() != 0) ? model_q[0] : '0;
        if (BYP && model_q.size() == 0 && fe_queue_v_i && !clr_i && !reset_i) begin
            exp_v = 1'b1;
            exp_d = fe_queue_i;
        end
        check("v_o",     64'(fe_queue_v_o), 64'(exp_v));
        check("empty_o", 64'(empty_o),      64'(model_q.size() == 0));
        check("count_o", 64'(count_o),      64'(model_q.size()));
        check("ready_o", 64'(fe_queue_ready_o),
              64'(!reset_i && model_q.size() < ELS));
        if (exp_v) check("data_o", 64'(fe_queue_o), 64'(exp_d));
        if (fe_queue_yumi_i) check("yumi_protocol", 64'(fe_queue_v_o), 64'(1));
    endtask

    // Model state after a rising edge, using the inputs that were sampled there
    task automatic model_update();
        bit full_pre;
        if (reset_i || clr_i) begin
            model_q.delete();
            return;
        end
        if (BYP && model_q.size() == 0 && fe_queue_v_i && fe_queue_yumi_i) return;
        full_pre = (model_q.size() == ELS);
        if (fe_queue_yumi_i && model_q.size() != 0) void'(model_q.pop_front());
        if (fe_queue_v_i && !full_pre) model_q.push_back(fe_queue_i);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic y, input logic c);
        fe_queue_v_i    = v;
        fe_queue_i      = d;
        fe_queue_yumi_i = y;
        clr_i           = c;
    endtask

    // One full cycle: compare at the falling edge, then advance the model at
    // the rising edge. The task returns 1 ns after that edge.
    task automatic tick();
        @(negedge clk_i);
        compare_outputs();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic idle_settle();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        logic          v, y, c;
        logic [W-1:0]  d;

        reset_i = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_ready", 64'(fe_queue_ready_o), 64'(0));
        check("reset_count", 64'(count_o),          64'(0));
        reset_i = 1'b0;
        #1;
        check("post_reset_ready", 64'(fe_queue_ready_o), 64'(1));
        check("post_reset_v",     64'(fe_queue_v_o),     64'(0));
        check("post_reset_count", 64'(count_o),          64'(0));

        // Fill with 0x11..0x18, then drain in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, W'(32'h11 + i), 1'b0, 1'b0);
            tick();
        end
        idle_settle();
        check("fill_ready", 64'(fe_queue_ready_o), 64'(0));
        check("fill_count", 64'(count_o),          64'(8));
        for (int i = 0; i < 8; i++) begin
            check("drain_data", 64'(fe_queue_o), 64'(32'h11 + i));
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        idle_settle();
        check("drain_empty", 64'(empty_o), 64'(1));

        // Full buffer, offer and dequeue in the same cycle: the offer is refused
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, W'(32'h11 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h99, 1'b1, 1'b0);
        tick();
        idle_settle();
        check("fulldeq_count", 64'(count_o),          64'(7));
        check("fulldeq_ready", 64'(fe_queue_ready_o), 64'(1));
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            idle_settle();
            check("fulldeq_order", 64'(fe_queue_o), 64'((i < 7) ? (32'h12 + i) : 32'h99));
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
        end

        // Wrap-around: preload 3, then stream 20 with one enqueue and one dequeue per cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, W'(32'h200 + i), 1'b1, 1'b0);
            #1;
            check("wrap_data", 64'(fe_queue_o), 64'((i < 3) ? (32'h100 + i) : (32'h200 + i - 3)));
            tick();
            check("wrap_count", 64'(count_o), 64'(3));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
        end

        // Flush with a poisoned offer of 0xAA and an ignored yumi
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'(32'h300 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hAA, 1'b1, 1'b1);
        tick();
        idle_settle();
        check("flush_count", 64'(count_o),      64'(0));
        check("flush_v",     64'(fe_queue_v_o), 64'(0));
        drive(1'b1, 32'hBB, 1'b0, 1'b0);
        tick();
        idle_settle();
        check("flush_head", 64'(fe_queue_o), 64'(32'hBB));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // Asynchronous reset pulse between edges with 4 entries stored
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(32'h400 + i), 1'b0, 1'b0);
            tick();
        end
        idle_settle();
        reset_i = 1'b1;
        #1;
        check("areset_v",     64'(fe_queue_v_o), 64'(0));
        check("areset_count", 64'(count_o),      64'(0));
        check("areset_empty", 64'(empty_o),      64'(1));
        model_q.delete();
        reset_i = 1'b0;
        tick();

        // Offer 0x55 into an empty buffer
`ifdef BP_FE_QUEUE_BYPASS_EN
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        #1;
        check("bypass_data", 64'(fe_queue_o),   64'(32'h55));
        check("bypass_v",    64'(fe_queue_v_o), 64'(1));
        tick();
        idle_settle();
        check("bypass_count", 64'(count_o), 64'(0));
`else
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        #1;
        check("nobypass_v", 64'(fe_queue_v_o), 64'(0));
        tick();
        idle_settle();
        check("nobypass_data", 64'(fe_queue_o), 64'(32'h55));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
`endif

        // Random traffic; yumi is only raised when the model says the head is valid
        for (int i = 0; i < 3000; i++) begin
            v = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 19) == 0);
            d = $urandom;
            y = ((model_q.size() != 0) || (BYP && v && !c)) && ($urandom_range(0, 2) != 0);
            drive(v, d, y, c);
            tick();
        end
        idle_settle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
